// File: rtl/mips_cache_controller.sv
// rtl/mips_cache_controller.sv - miss fill and write-through engine between the data cache and the memory bus
module mips_cache_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byte_en,
    input  logic             cache_stall,
    output logic [31:0]      data_in,
    output logic             data_valid,
    output logic             cpu_stall,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byteenable,
    output logic [31:0]      mem_writedata,
    input  logic             mem_waitrequest,
    input  logic [31:0]      mem_readdata,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ,
        WR_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // The bus is word addressed; the byte offset of the CPU address is dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    assign mem_address    = {addr[31:2], 2'b00};
    assign mem_writedata  = writedata;
    assign mem_byteenable = mem_write ? byte_en : 4'b1111;

    // State register; reset aborts any bus cycle immediately because bus strobes decode from state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the read word the cycle after the bus accepted the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_in <= '0;
        end else if (state == RD_WAIT) begin
            data_in <= mem_readdata;
        end
    end

    // Count one miss per fill, holding at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count <= '0;
        end else if (state == FILL && miss_count != {CNT_W{1'b1}}) begin
            miss_count <= miss_count + CNT_W'(1);
        end
    end

    // Next-state decode and per-state bus/CPU strobes.
    always_comb begin
        state_next = state;
        cpu_stall  = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        data_valid = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = cache_stall | write_en;
                // A miss is always filled first, so a write miss becomes a write hit afterwards.
                if ((read_en || write_en) && cache_stall) begin
                    state_next = RD_REQ;
                end else if (write_en) begin
                    state_next = WR_REQ;
                end
            end
            RD_REQ: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_next = FILL;
            end
            FILL: begin
                data_valid = 1'b1;
                state_next = IDLE;
            end
            WR_REQ: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = WR_DONE;
                end
            end
            WR_DONE: begin
                // Single unstalled cycle lets the CPU retire the store.
                cpu_stall  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_cache_controller.sv
// tb/tb_mips_cache_controller.sv - directed self-checking bench for mips_cache_controller
module tb_mips_cache_controller;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] writedata;
    logic [3:0]  byte_en;
    logic        cache_stall;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    logic [31:0] data_in;
    logic        data_valid;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [15:0] miss_count;

    logic [31:0] data_in_b;
    logic        data_valid_b;
    logic        cpu_stall_b;
    logic [31:0] mem_address_b;
    logic        mem_read_b;
    logic        mem_write_b;
    logic [3:0]  mem_byteenable_b;
    logic [31:0] mem_writedata_b;
    logic [1:0]  miss_count_b;

    mips_cache_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
        .writedata(writedata), .byte_en(byte_en), .cache_stall(cache_stall),
        .data_in(data_in), .data_valid(data_valid), .cpu_stall(cpu_stall),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .miss_count(miss_count)
    );

    mips_cache_controller #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
        .writedata(writedata), .byte_en(byte_en), .cache_stall(cache_stall),
        .data_in(data_in_b), .data_valid(data_valid_b), .cpu_stall(cpu_stall_b),
        .mem_address(mem_address_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_byteenable(mem_byteenable_b), .mem_writedata(mem_writedata_b),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .miss_count(miss_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny cache model: one valid bit per word, installed on a fill strobe.
    logic       cached [0:255];
    logic       inval_req;
    logic [7:0] inval_idx;
    initial begin
        for (int i = 0; i < 256; i++) cached[i] = 1'b0;
    end
    always @(posedge clk) begin
        if (inval_req) cached[inval_idx] <= 1'b0;
        else if (data_valid) cached[addr[9:2]] <= 1'b1;
    end
    assign cache_stall = (read_en | write_en) & ~cached[addr[9:2]];

    typedef struct {
        bit          st;
        bit          rd;
        bit          wr;
        bit          dv;
        logic [31:0] din;
        logic [31:0] maddr;
        logic [3:0]  be;
        int          cnt;
    } rec_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    rec_t exp_q[$];
    lit_t lit_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    int   dv_pulses = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (mem_read) rd_cycles++;
        if (mem_write) wr_cycles++;
        if (data_valid) dv_pulses++;
    end

    // Single compare process: expected cycle records, then literal pins.
    always @(negedge clk) begin
        rec_t e;
        lit_t l;
        if (rst) chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e.st});
            chk("mem_read", {31'b0, mem_read}, {31'b0, e.rd});
            chk("mem_write", {31'b0, mem_write}, {31'b0, e.wr});
            chk("data_valid", {31'b0, data_valid}, {31'b0, e.dv});
            if (e.dv) chk("data_in", data_in, e.din);
            if (e.rd || e.wr) begin
                chk("mem_address", mem_address, e.maddr);
                chk("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, e.be});
            end
            if (e.wr) chk("mem_writedata", mem_writedata, writedata);
            chk("miss_count", {16'b0, miss_count}, e.cnt);
            chk("miss_count_sat", {30'b0, miss_count_b}, (e.cnt > 3) ? 32'd3 : e.cnt);
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.nm, l.act, l.exp);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_t l;
        l.nm = nm; l.act = act; l.exp = exp;
        lit_q.push_back(l);
    endtask

    // One bus cycle of expected behaviour, called just after a rising edge.
    task automatic step(input bit st, input bit rd, input bit wr, input bit dv,
                        input logic [31:0] din, input logic wt, input logic [31:0] rdat);
        rec_t e;
        mem_waitrequest = wt;
        mem_readdata    = rdat;
        e.st = st; e.rd = rd; e.wr = wr; e.dv = dv; e.din = din;
        e.maddr = {addr[31:2], 2'b00};
        e.be    = wr ? byte_en : 4'b1111;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Miss handling: request (with wait states), data phase, fill strobe.
    task automatic fill(input int waits, input logic [31:0] rdat);
        step(1, 0, 0, 0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < waits; i++) step(1, 1, 0, 0, 32'h0, 1'b1, 32'hBAD0BAD0);
        step(1, 1, 0, 0, 32'h0, 1'b0, 32'hBAD0BAD0);
        step(1, 0, 0, 0, 32'h0, 1'b1, rdat);
        step(1, 0, 0, 1, rdat, 1'b1, ~rdat);
        exp_cnt++;
    endtask

    task automatic read_op(input logic [31:0] a, input logic [31:0] rdat, input int waits);
        addr = a; read_en = 1'b1; write_en = 1'b0;
        if (!cached[a[9:2]]) fill(waits, rdat);
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        read_en = 1'b0;
    endtask

    task automatic write_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            input int waits);
        addr = a; write_en = 1'b1; read_en = 1'b0; writedata = wd; byte_en = be;
        if (!cached[a[9:2]]) fill(0, 32'hCAFE0000 | a);
        step(1, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < waits; i++) step(1, 0, 1, 0, 32'h0, 1'b1, 32'h0);
        step(1, 0, 1, 0, 32'h0, 1'b0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        write_en = 1'b0;
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
    endtask

    int n_rd;
    int n_wr;
    int n_dv;

    initial begin
        rst = 1'b0; addr = 32'h0; read_en = 1'b0; write_en = 1'b0;
        writedata = 32'h0; byte_en = 4'h0; mem_waitrequest = 1'b0; mem_readdata = 32'h0;
        inval_req = 1'b0; inval_idx = 8'h0;
        #3;
        lit("reset_mem_read", {31'b0, mem_read}, 32'd0);
        lit("reset_data_valid", {31'b0, data_valid}, 32'd0);
        lit("reset_data_in", data_in, 32'd0);
        lit("reset_miss_count", {16'b0, miss_count}, 32'd0);
        lit("reset_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);

        // Reset in the middle of a stalled bus read.
        addr = 32'h100; read_en = 1'b1;
        step(1, 0, 0, 0, 32'h0, 1'b1, 32'h0);
        step(1, 1, 0, 0, 32'h0, 1'b1, 32'h0);
        #2;
        lit("pre_reset_mem_read", {31'b0, mem_read}, 32'd1);
        rst = 1'b0;
        #1;
        lit("async_reset_mem_read", {31'b0, mem_read}, 32'd0);
        lit("async_reset_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        lit("async_reset_miss_count", {16'b0, miss_count}, 32'd0);
        read_en = 1'b0;
        #1;
        lit("reset_idle_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);

        // Read miss, zero wait states.
        n_rd = rd_cycles; n_dv = dv_pulses;
        read_op(32'h40, 32'hDEADBEEF, 0);
        lit("t2_rd_cycles", rd_cycles - n_rd, 32'd1);
        lit("t2_dv_pulses", dv_pulses - n_dv, 32'd1);
        lit("t2_miss_count", {16'b0, miss_count}, 32'd1);
        lit("t2_data_in", data_in, 32'hDEADBEEF);

        // Same word evicted, refetched with three wait states.
        inval_req = 1'b1; inval_idx = 8'd16;
        @(posedge clk); #1;
        inval_req = 1'b0;
        n_rd = rd_cycles; n_dv = dv_pulses;
        read_op(32'h40, 32'h0BADF00D, 3);
        lit("t3_rd_cycles", rd_cycles - n_rd, 32'd4);
        lit("t3_dv_pulses", dv_pulses - n_dv, 32'd1);
        lit("t3_miss_count", {16'b0, miss_count}, 32'd2);

        // Bring 0x44 in, then a write hit with partial byte enables.
        read_op(32'h44, 32'h11112222, 0);
        n_rd = rd_cycles; n_wr = wr_cycles; n_dv = dv_pulses;
        write_op(32'h44, 32'h12345678, 4'b0011, 0);
        lit("t4_wr_cycles", wr_cycles - n_wr, 32'd1);
        lit("t4_rd_cycles", rd_cycles - n_rd, 32'd0);
        lit("t4_dv_pulses", dv_pulses - n_dv, 32'd0);
        lit("t4_miss_count", {16'b0, miss_count}, 32'd3);

        // Write miss: fill first, then the write.
        n_rd = rd_cycles; n_wr = wr_cycles;
        write_op(32'h48, 32'hA5A5A5A5, 4'b1111, 0);
        lit("t5_rd_cycles", rd_cycles - n_rd, 32'd1);
        lit("t5_wr_cycles", wr_cycles - n_wr, 32'd1);
        lit("t5_miss_count", {16'b0, miss_count}, 32'd4);

        // Write with no byte enables and bus wait states.
        write_op(32'h44, 32'h87654321, 4'b0000, 2);

        // More misses push the narrow counter past saturation.
        read_op(32'h4C, 32'h01020304, 1);
        read_op(32'h50, 32'hFFFF0000, 0);
        read_op(32'h50, 32'h0, 0);
        lit("t6_miss_count_sat", {30'b0, miss_count_b}, 32'd3);
        lit("t6_miss_count", {16'b0, miss_count}, 32'd6);
        step(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
